// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared types and helpers for the pipelined chunk adder.
//   stage_ctl_t  : per-stage control record (carry out of the slice, stage valid)
//   chunk_count  : number of pipeline stages for a given operand/slice width
package adder_pkg;

    typedef struct packed {
        logic carry;
        logic vld;
    } stage_ctl_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_chunk_adder_if.sv
// Handshake bus of the pipelined chunk adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : adder side (drives in_ready and the result)
//   in_valid/in_ready  : operand handshake (a, b, cin, sub)
//   out_valid/out_ready: result handshake (sum, cout, ovf)
interface pipelined_chunk_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_chunk_adder_chunk_stage.sv
// One pipeline stage of the chunk adder: CHUNK-bit ripple-carry add of one
// operand slice plus the incoming carry, registered with a hold enable.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance enable; register holds when low
//   vld_in   : valid bit travelling with this slice
//   a_s, b_s : operand slices (b already inverted for subtraction)
//   ci       : carry into the slice
//   s_q      : registered slice sum
//   ctl_q    : registered carry out and valid
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vld_in,
    input  logic [CHUNK-1:0] a_s,
    input  logic [CHUNK-1:0] b_s,
    input  logic             ci,
    output logic [CHUNK-1:0] s_q,
    output stage_ctl_t       ctl_q
);

    logic [CHUNK-1:0] s_c;
    logic             c_c;

    always_comb begin
        s_c = '0;
        c_c = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s_c[i] = a_s[i] ^ b_s[i] ^ c_c;
            c_c    = (a_s[i] & b_s[i]) | (c_c & (a_s[i] ^ b_s[i]));
        end
    end

    // stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            ctl_q <= '0;
        end else if (en) begin
            s_q         <= s_c;
            ctl_q.carry <= c_c;
            ctl_q.vld   <= vld_in;
        end
    end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined ripple-carry adder/subtractor. WIDTH-bit operands are split into
// CHUNK-bit slices; slice k is added in stage k and the carry is registered
// between stages, giving a latency of WIDTH/CHUNK cycles at one op per cycle.
// A single global advance signal stalls every stage under back-pressure.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipelined_chunk_adder_if
//              (in_valid/in_ready, a, b, cin, sub, out_valid/out_ready,
//               sum, cout, ovf)
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_chunk_adder_if.slave bus
);

    localparam int STAGES = chunk_count(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff_in;
    logic             cin_eff;
    logic [WIDTH-1:0] sum_full;

    // Subtraction is A + ~B + 1; cin is ignored in that case.
    assign b_eff_in = bus.sub ? ~bus.b : bus.b;
    assign cin_eff  = bus.sub | bus.cin;

    // The pipe only stops when a finished result is waiting on the consumer.
    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits from slice k upward, as seen at the input of stage k.
        localparam int UPW = WIDTH - k * CHUNK;

        logic [UPW-1:0]   a_up;
        logic [UPW-1:0]   b_up;
        logic             ci;
        logic             vld_in;
        logic [1:0]       msb_in;
        logic [CHUNK-1:0] s_q;
        stage_ctl_t       ctl_q;
        logic [1:0]       msb_p;   // {a MSB, b_eff MSB}, carried to the overflow check

        if (k == 0) begin : g_src
            assign a_up   = bus.a;
            assign b_up   = b_eff_in;
            assign ci     = cin_eff;
            assign vld_in = bus.in_valid;
            assign msb_in = {bus.a[WIDTH-1], b_eff_in[WIDTH-1]};
        end else begin : g_src
            assign a_up   = g_stage[k-1].g_fwd.a_p;
            assign b_up   = g_stage[k-1].g_fwd.b_p;
            assign ci     = g_stage[k-1].ctl_q.carry;
            assign vld_in = g_stage[k-1].ctl_q.vld;
            assign msb_in = g_stage[k-1].msb_p;
        end

        adder_chunk_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (adv),
            .vld_in (vld_in),
            .a_s    (a_up[CHUNK-1:0]),
            .b_s    (b_up[CHUNK-1:0]),
            .ci     (ci),
            .s_q    (s_q),
            .ctl_q  (ctl_q)
        );

        // stage k register: operand MSBs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                msb_p <= '0;
            end else if (adv) begin
                msb_p <= msb_in;
            end
        end

        // Operand skew: only the slices not yet consumed move forward.
        if (k < LAST) begin : g_fwd
            logic [UPW-CHUNK-1:0] a_p;
            logic [UPW-CHUNK-1:0] b_p;

            // stage k register: remaining operand slices
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_p <= '0;
                    b_p <= '0;
                end else if (adv) begin
                    a_p <= a_up[UPW-1:CHUNK];
                    b_p <= b_up[UPW-1:CHUNK];
                end
            end
        end

        // Result skew: sum slices already produced by earlier stages.
        if (k > 0) begin : g_lo
            logic [k*CHUNK-1:0] lo_p;

            if (k == 1) begin : g_cat
                // stage k register: low sum slices
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        lo_p <= '0;
                    end else if (adv) begin
                        lo_p <= g_stage[0].s_q;
                    end
                end
            end else begin : g_cat
                // stage k register: low sum slices
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        lo_p <= '0;
                    end else if (adv) begin
                        lo_p <= {g_stage[k-1].s_q, g_stage[k-1].g_lo.lo_p};
                    end
                end
            end
        end
    end

    if (STAGES == 1) begin : g_sum
        assign sum_full = g_stage[0].s_q;
    end else begin : g_sum
        assign sum_full = {g_stage[LAST].s_q, g_stage[LAST].g_lo.lo_p};
    end

    assign bus.out_valid = g_stage[LAST].ctl_q.vld;
    assign bus.cout      = g_stage[LAST].ctl_q.carry;
    assign bus.sum       = sum_full;
    assign bus.ovf       = signed_ovf(g_stage[LAST].msb_p[1], g_stage[LAST].msb_p[0],
                                      sum_full[WIDTH-1]);

endmodule
